// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner codes
// and the round-robin winner selection.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_AXI = 1'b1;

    // On a tie the port that did not win last time takes the slot.
    function automatic logic pick_winner(input logic cpu_req, input logic axi_req,
                                         input logic owner);
        if (cpu_req && axi_req) return ~owner;
        else if (axi_req)       return OWNER_AXI;
        else                    return OWNER_CPU;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Two-port (CPU / AXI host) arbiter in front of a single-port data memory
// with one-cycle read latency; round-robin on ties, one access in flight.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,

    input  logic                axi_req,
    input  logic                axi_we,
    input  logic [ADDR_W-1:0]   axi_addr,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_gnt,
    output logic                axi_rvalid,
    output logic [DATA_W-1:0]   axi_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                owner,
    output logic [15:0]         contention_cnt
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                owner_q;
    logic [15:0]         cnt_q;
    logic                cpu_rvalid_q, axi_rvalid_q;
    logic [DATA_W-1:0]   cpu_rdata_q, axi_rdata_q;

    logic any_req, both_req, win;

    assign any_req  = cpu_req | axi_req;
    assign both_req = cpu_req & axi_req;
    assign win      = pick_winner(cpu_req, axi_req, owner_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        cpu_gnt   = 1'b0;
        axi_gnt   = 1'b0;
        case (state_q)
            IDLE: if (any_req) state_d = CMD;
            CMD: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                cpu_gnt   = (win_q == OWNER_CPU);
                axi_gnt   = (win_q == OWNER_AXI);
                state_d   = we_q ? IDLE : RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture, ownership and contention statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= OWNER_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            owner_q <= OWNER_AXI;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                win_q   <= win;
                we_q    <= (win == OWNER_AXI) ? axi_we    : cpu_we;
                addr_q  <= (win == OWNER_AXI) ? axi_addr  : cpu_addr;
                wdata_q <= (win == OWNER_AXI) ? axi_wdata : cpu_wdata;
                wstrb_q <= (win == OWNER_AXI) ? axi_wstrb : cpu_wstrb;
                if (both_req && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == CMD) owner_q <= win_q;
        end
    end

    // Read return: memory data arrives during RESP, presented the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            axi_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            axi_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= (state_q == RESP) && (win_q == OWNER_CPU);
            axi_rvalid_q <= (state_q == RESP) && (win_q == OWNER_AXI);
            if (state_q == RESP && win_q == OWNER_CPU) cpu_rdata_q <= mem_rdata;
            if (state_q == RESP && win_q == OWNER_AXI) axi_rdata_q <= mem_rdata;
        end
    end

    assign cpu_rvalid     = cpu_rvalid_q;
    assign axi_rvalid     = axi_rvalid_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign axi_rdata      = axi_rdata_q;
    assign owner          = owner_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed stimulus pushes expected
// grant/read events, a negedge monitor pops and compares them.
module tb_riscv_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [SW-1:0] cpu_wstrb = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          axi_req = 1'b0, axi_we = 1'b0;
    logic [AW-1:0] axi_addr = '0;
    logic [DW-1:0] axi_wdata = '0;
    logic [SW-1:0] axi_wstrb = '0;
    logic          axi_gnt, axi_rvalid;
    logic [DW-1:0] axi_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;
    logic          owner;
    logic [15:0]   contention_cnt;

    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_gnt(axi_gnt),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .owner(owner), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: byte-strobed writes, one-cycle read latency, backdoor load.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) tb_mem[ld_addr] <= ld_data;
        else if (mem_en && mem_we)
            for (int b = 0; b < SW; b++)
                if (mem_wstrb[b]) tb_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= tb_mem[mem_addr];
    end

    typedef struct {
        logic          port;   // 0 CPU, 1 AXI
        logic          rv;     // 0 grant, 1 read return
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic rv, input logic [DW-1:0] data);
        exp_t e;
        e.port = port; e.rv = rv; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic port, input logic rv, input logic [DW-1:0] data);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: port %0d rv %0d data %h with nothing expected",
                     port, rv, data);
        end else begin
            e = exp_q.pop_front();
            if (e.port !== port || e.rv !== rv || (rv && e.data !== data)) begin
                errors++;
                $display("FAIL sb_event: got port %0d rv %0d data %h expected port %0d rv %0d data %h",
                         port, rv, data, e.port, e.rv, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_gnt)    sb_pop(1'b0, 1'b0, '0);
            if (axi_gnt)    sb_pop(1'b1, 1'b0, '0);
            if (cpu_rvalid) sb_pop(1'b0, 1'b1, cpu_rdata);
            if (axi_rvalid) sb_pop(1'b1, 1'b1, axi_rdata);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_cmd(input logic port, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (!port) begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
        end else begin
            axi_req = req; axi_we = we; axi_addr = a; axi_wdata = d; axi_wstrb = s;
        end
    endtask

    task automatic wait_gnt(input logic port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (port ? axi_gnt : cpu_gnt) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout: port %0d got no grant in 50 cycles, grant required", port);
    endtask

    // n back-to-back writes, holding req high between them; drop req after the last.
    task automatic port_seq(input logic port, input int n, input logic [AW-1:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            set_cmd(port, 1'b1, 1'b1, base + AW'(i), DW'(i) + 32'h100, '1);
            wait_gnt(port, ok);
            tick();
        end
        set_cmd(port, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic req_once(input logic port, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok;
        set_cmd(port, 1'b1, we, a, d, s);
        wait_gnt(port, ok);
        tick();
        set_cmd(port, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
        tick(); tick();
        chk("rst_cpu_gnt",    32'(cpu_gnt), 32'd0);
        chk("rst_axi_gnt",    32'(axi_gnt), 32'd0);
        chk("rst_rvalids",    32'({cpu_rvalid, axi_rvalid}), 32'd0);
        chk("rst_mem_en_we",  32'({mem_en, mem_we}), 32'd0);
        chk("rst_mem_addr",   32'(mem_addr), 32'd0);
        chk("rst_mem_wdata",  mem_wdata, 32'd0);
        chk("rst_mem_wstrb",  32'(mem_wstrb), 32'd0);
        chk("rst_owner",      32'(owner), 32'd1);
        chk("rst_cnt",        32'(contention_cnt), 32'd0);
        chk("rst_cpu_rdata",  cpu_rdata, 32'd0);
        chk("rst_axi_rdata",  axi_rdata, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1ms, completion required");
        $fatal(1, "watchdog");
    end

    initial begin
        // Backdoor preload while in reset.
        #1;
        ld_en = 1'b1; ld_addr = 12'h010; ld_data = 32'hDEADBEEF;
        tick();
        ld_addr = 12'h020; ld_data = 32'h0;
        tick();
        ld_en = 1'b0;

        // CPU read only, latency N+1 grant, N+3 data.
        do_reset();
        push(1'b0, 1'b0, '0);
        push(1'b0, 1'b1, 32'hDEADBEEF);
        set_cmd(1'b0, 1'b1, 1'b0, 12'h010, '0, '1);
        tick();
        chk("rd_gnt_n1",      32'(cpu_gnt), 32'd1);
        chk("rd_mem_en_n1",   32'(mem_en), 32'd1);
        chk("rd_mem_we_n1",   32'(mem_we), 32'd0);
        chk("rd_mem_addr_n1", 32'(mem_addr), 32'h010);
        chk("rd_axi_gnt_n1",  32'(axi_gnt), 32'd0);
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("rd_rvalid_n2",   32'(cpu_rvalid), 32'd0);
        chk("rd_mem_en_n2",   32'(mem_en), 32'd0);
        tick();
        chk("rd_rvalid_n3",   32'(cpu_rvalid), 32'd1);
        chk("rd_rdata_n3",    cpu_rdata, 32'hDEADBEEF);
        chk("rd_axi_quiet",   32'({axi_rvalid, axi_gnt}), 32'd0);
        chk("rd_axi_rdata",   axi_rdata, 32'd0);
        chk("rd_owner",       32'(owner), 32'd0);
        tick();
        chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

        // Simultaneous after reset: CPU write wins, AXI reads it back.
        do_reset();
        push(1'b0, 1'b0, '0);
        push(1'b1, 1'b0, '0);
        push(1'b1, 1'b1, 32'h11);
        fork
            req_once(1'b0, 1'b1, 12'h004, 32'h11, '1);
            req_once(1'b1, 1'b0, 12'h004, '0, '1);
        join
        repeat (3) tick();
        chk("tie_cnt",   32'(contention_cnt), 32'd1);
        chk("tie_owner", 32'(owner), 32'd1);
        chk("tie_axi_rdata", axi_rdata, 32'h11);

        // Fairness: 8 contended grants alternate starting with CPU.
        do_reset();
        for (int i = 0; i < 9; i++) push(i[0], 1'b0, '0);
        fork
            port_seq(1'b0, 5, 12'h100);
            port_seq(1'b1, 4, 12'h200);
        join
        tick();
        chk("fair_cnt",   32'(contention_cnt), 32'd8);
        chk("fair_owner", 32'(owner), 32'd0);

        // Saturation: preset near the top, then 5 contended decisions.
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        chk("sat_preset", 32'(contention_cnt), 32'hFFFD);
        for (int i = 0; i < 6; i++) push(~i[0], 1'b0, '0);
        fork
            port_seq(1'b0, 3, 12'h300);
            port_seq(1'b1, 3, 12'h400);
        join
        tick();
        chk("sat_cnt", 32'(contention_cnt), 32'hFFFF);

        // Reset in the CMD cycle of an AXI read.
        begin
            bit ok;
            set_cmd(1'b1, 1'b1, 1'b0, 12'h010, '0, '1);
            wait_gnt(1'b1, ok);
            rst_n = 1'b0;
            #1;
            chk("mid_mem_en",  32'(mem_en), 32'd0);
            chk("mid_axi_gnt", 32'(axi_gnt), 32'd0);
            chk("mid_owner",   32'(owner), 32'd1);
            chk("mid_cnt",     32'(contention_cnt), 32'd0);
            set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
            tick(); tick();
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("mid_no_rvalid", 32'(axi_rvalid), 32'd0);
            end
            chk("mid_axi_rdata", axi_rdata, 32'd0);
        end

        // Byte strobes, and non-winning port rdata untouched.
        push(1'b0, 1'b0, '0);
        req_once(1'b0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101);
        push(1'b0, 1'b0, '0);
        push(1'b0, 1'b1, 32'h00BB00DD);
        req_once(1'b0, 1'b0, 12'h020, '0, '1);
        repeat (3) tick();
        chk("strb_cpu_rdata", cpu_rdata, 32'h00BB00DD);
        chk("strb_axi_rdata", axi_rdata, 32'd0);

        // Request withdrawn between edges: never sampled.
        #2 axi_req = 1'b1;
        #2 axi_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wd_mem_en",  32'(mem_en), 32'd0);
            chk("wd_axi_gnt", 32'(axi_gnt), 32'd0);
        end
        chk("wd_cnt", 32'(contention_cnt), 32'd0);

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: word address width of the shared data memory.
REQ-002 Parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU requests an access.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  ADDR_W  word address.
REQ-008 cpu_wdata  input  DATA_W  write data.
REQ-009 cpu_wstrb  input  DATA_W/8  byte strobes.
REQ-010 cpu_gnt  output  1  one-cycle pulse: CPU command issued to memory.
REQ-011 cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-012 cpu_rdata  output  DATA_W  read data.
REQ-013 axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb, axi_gnt, axi_rvalid, axi_rdata: identical widths and meanings to the cpu_* set, for the host bus port.
REQ-014 mem_en  output  1  memory command strobe.
REQ-015 mem_we  output  1  memory write enable, valid with mem_en.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_wstrb  output  DATA_W/8.
REQ-017 mem_rdata  input  DATA_W  valid exactly one cycle after a read command.
REQ-018 owner  output  1  0 = CPU, 1 = AXI; requester granted most recently.
REQ-019 contention_cnt  output  16  count of arbitration decisions with both requests high.

Function
REQ-020 FSM states: IDLE, CMD, RESP.
REQ-021 IDLE: if neither request is high, stay IDLE; otherwise latch the winner's we/addr/wdata/wstrb and go to CMD.
REQ-022 Arbitration: a single requester wins; with both high, the requester not equal to owner wins (round-robin).
REQ-023 CMD: drive mem_en=1 with the latched command for exactly one cycle; pulse the winner's gnt; update owner; next state RESP for a read, IDLE for a write.
REQ-024 RESP: capture mem_rdata into the winner's rdata register; pulse the winner's rvalid for one cycle; next state IDLE.
REQ-025 Latency: request sampled in cycle N -> gnt and mem_en in cycle N+1 -> rvalid in cycle N+3 (rdata valid from N+3); write completes at N+1.
REQ-026 Requester holds req and its command stable through the gnt cycle and deasserts req the following cycle unless it issues a new request; requests are sampled only in IDLE.
REQ-027 Back-to-back throughput: one write per 2 cycles; one read per 3 cycles.
REQ-028 rdata registers hold their last value until the next read for that port; the non-winning port's rdata is unchanged.
REQ-029 mem_en, mem_we, gnt and rvalid are 0 outside the states above; mem_we=0 in RESP.
REQ-030 contention_cnt increments by 1 on each IDLE->CMD transition with both requests high; saturates at 16'hFFFF.
REQ-031 Request deasserted before grant: no command issued, no error.

Reset
REQ-032 rst_n low asynchronously forces state IDLE; all gnt, rvalid and mem_* outputs 0; owner = 1 (AXI), so the CPU wins the first tie; contention_cnt 0; both rdata 0.
REQ-033 Reset during CMD or RESP discards the access; no rvalid is produced after reset release.
REQ-034 First arbitration occurs in the first cycle after rst_n deasserts.

Structure
REQ-035 FSM state encoding and owner encodings (OWNER_CPU=0, OWNER_AXI=1) live in the shared riscv_pkg package.
REQ-036 Single flat module; no sub-module is required.

Verification
REQ-037 CPU read only: cpu_req=1, addr=12'h010, memory holds 32'hDEADBEEF -> cpu_gnt at N+1, cpu_rvalid with cpu_rdata=32'hDEADBEEF at N+3, axi_* outputs quiet.
REQ-038 Simultaneous requests after reset: CPU write addr 12'h004 data 32'h11 and AXI read addr 12'h004 -> CPU granted first (mem write), AXI granted next and reads 32'h11; contention_cnt=1.
REQ-039 Fairness: both ports request continuously for 8 grants -> grants alternate CPU, AXI, CPU, ...; owner toggles; contention_cnt=8.
REQ-040 Saturation: force 65 540 contended decisions -> contention_cnt stays at 16'hFFFF.
REQ-041 Reset mid-read: assert rst_n=0 in the CMD cycle of an AXI read -> outputs 0 immediately, no axi_rvalid after release, state IDLE.
REQ-042 Request withdrawal: axi_req high for 0 cycles past IDLE check (drops before sampling) -> no mem_en, no axi_gnt.
